// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
// Hardware sequencer for the user GPIO configuration shift chains. A single
// start pulse walks every pad from NPADS-1 down to 0, fetches its two
// configuration words from the register file, and shifts both chains in
// lockstep MSB first. It then strobes serial_load. With bitbang_en set while
// idle, the bb_* control bits are registered straight onto the chain outputs.
module gpio_serial_loader #(
  parameter int NPADS    = 19,
  parameter int CFG_BITS = 13,
  parameter int CLKDIV   = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rstn_i,
  input  logic                      xfer_start,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NPADS)-1:0]  cfg_idx,
  input  logic [CFG_BITS-1:0]       cfg_data_1,
  input  logic [CFG_BITS-1:0]       cfg_data_2,
  input  logic                      bitbang_en,
  input  logic                      bb_clock,
  input  logic                      bb_load,
  input  logic                      bb_resetn,
  input  logic                      bb_data_1,
  input  logic                      bb_data_2,
  output logic                      serial_clock,
  output logic                      serial_load,
  output logic                      serial_resetn,
  output logic                      serial_data_1,
  output logic                      serial_data_2
);

  localparam int IDX_W = $clog2(NPADS);
  localparam int BIT_W = $clog2(CFG_BITS + 1);
  localparam int DIV_W = $clog2(2 * CLKDIV + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NPADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CFG_BITS - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] LOAD_LAST = DIV_W'(2 * CLKDIV - 1);
  localparam logic [DIV_W-1:0] LOAD_HIGH = DIV_W'(CLKDIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD
  } state_e;

  // Registered chain control bundle; every field resets to 0.
  typedef struct packed {
    logic clock;
    logic load;
    logic resetn;
    logic data_1;
    logic data_2;
  } serial_t;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      cfg_idx_q, cfg_idx_d;
  logic [CFG_BITS-1:0]   sr1_q, sr1_d;
  logic [CFG_BITS-1:0]   sr2_q, sr2_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  serial_t               ser_q, ser_d;
  logic                  bb_sel;

  // State register and all datapath/output flops.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      // NOTE: clocked state is updated only with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      cfg_idx_q <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ser_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_idx_q <= cfg_idx_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ser_q     <= ser_d;
    end
  end

  // Sequencing: mode select in IDLE, fetch, half-period timing, pad walk.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    cfg_idx_d = cfg_idx_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    bb_sel    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        if (bitbang_en) begin
          bb_sel = 1'b1;
        end else if (xfer_start) begin
          cfg_idx_d = IDX_LAST;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        sr1_d     = cfg_data_1;
        sr2_d     = cfg_data_2;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = ST_SHIFT_LO;
      end

      ST_SHIFT_LO: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d = '0;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_SHIFT_HI: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d = '0;
          sr1_d     = sr1_q << 1;
          sr2_d     = sr2_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q != BIT_LAST) begin
            state_d = ST_SHIFT_LO;
          end else if (cfg_idx_q != '0) begin
            // Next pad address is presented for the whole FETCH cycle.
            cfg_idx_d = cfg_idx_q - 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_LOAD: begin
        if (div_cnt_q == LOAD_LAST) begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up
  // with the state they describe.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_q == ST_LOAD) && (state_d == ST_IDLE);
    ser_d        = '0;
    ser_d.resetn = 1'b1;

    if (bb_sel) begin
      ser_d.clock  = bb_clock;
      ser_d.load   = bb_load;
      ser_d.resetn = bb_resetn;
      ser_d.data_1 = bb_data_1;
      ser_d.data_2 = bb_data_2;
    end else begin
      ser_d.clock = (state_d == ST_SHIFT_HI);
      ser_d.load  = (state_d == ST_LOAD) && (div_cnt_d < LOAD_HIGH);
      if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
        ser_d.data_1 = sr1_d[CFG_BITS-1];
        ser_d.data_2 = sr2_d[CFG_BITS-1];
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_idx       = cfg_idx_q;
  assign serial_clock  = ser_q.clock;
  assign serial_load   = ser_q.load;
  assign serial_resetn = ser_q.resetn;
  assign serial_data_1 = ser_q.data_1;
  assign serial_data_2 = ser_q.data_2;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader. Stimulus pushes the expected
// chain bitstream and transfer summary into queues; an independent monitor
// pops and compares on every serial_clock rise and every done pulse, and
// keeps a behavioural model of the physical shift chains.
module tb_gpio_serial_loader;

  localparam int NPADS    = 19;
  localparam int CFG_BITS = 13;
  localparam int CLKDIV   = 4;
  localparam int IDX_W    = $clog2(NPADS);
  localparam int NBITS    = NPADS * CFG_BITS;
  localparam int BUSY_LEN = NPADS * (1 + 2 * CLKDIV * CFG_BITS) + 2 * CLKDIV;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rstn_i = 1'b0;
  logic                 xfer_start = 1'b0;
  logic                 busy, done;
  logic [IDX_W-1:0]     cfg_idx;
  logic [CFG_BITS-1:0]  cfg_data_1, cfg_data_2;
  logic                 bitbang_en = 1'b0;
  logic                 bb_clock = 1'b0, bb_load = 1'b0, bb_resetn = 1'b0;
  logic                 bb_data_1 = 1'b0, bb_data_2 = 1'b0;
  logic                 serial_clock, serial_load, serial_resetn;
  logic                 serial_data_1, serial_data_2;

  gpio_serial_loader #(
    .NPADS(NPADS), .CFG_BITS(CFG_BITS), .CLKDIV(CLKDIV)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rstn_i    (wb_rstn_i),
    .xfer_start   (xfer_start),
    .busy         (busy),
    .done         (done),
    .cfg_idx      (cfg_idx),
    .cfg_data_1   (cfg_data_1),
    .cfg_data_2   (cfg_data_2),
    .bitbang_en   (bitbang_en),
    .bb_clock     (bb_clock),
    .bb_load      (bb_load),
    .bb_resetn    (bb_resetn),
    .bb_data_1    (bb_data_1),
    .bb_data_2    (bb_data_2),
    .serial_clock (serial_clock),
    .serial_load  (serial_load),
    .serial_resetn(serial_resetn),
    .serial_data_1(serial_data_1),
    .serial_data_2(serial_data_2)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Register-file model: combinational read of the words addressed by cfg_idx.
  logic [CFG_BITS-1:0] reg1 [NPADS];
  logic [CFG_BITS-1:0] reg2 [NPADS];

  always_comb begin
    cfg_data_1 = '0;
    cfg_data_2 = '0;
    if (int'(cfg_idx) < NPADS) begin
      cfg_data_1 = reg1[int'(cfg_idx)];
      cfg_data_2 = reg2[int'(cfg_idx)];
    end
  end

  typedef struct packed { logic b1; logic b2; } bits_t;
  typedef struct { int busy_len; int edges; } xfer_t;

  bits_t exp_bits [$];
  xfer_t exp_xfer [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s", name, what);
  endtask

  // Monitor state, shared read-only with the stimulus for timing decisions.
  int                busy_cnt, edge_cnt, load_pulses, load_width, done_cnt;
  logic              prev_clk, prev_load, prev_busy, prev_done;
  logic [NBITS-1:0]  chain1, chain2;

  initial begin
    bits_t e;
    xfer_t x;
    done_cnt = 0;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rstn_i) begin
        busy_cnt = 0; edge_cnt = 0; load_pulses = 0; load_width = 0;
        prev_clk = 1'b0; prev_load = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (busy && serial_clock && !prev_clk) begin
          edge_cnt++;
          chain1 = {chain1[NBITS-2:0], serial_data_1};
          chain2 = {chain2[NBITS-2:0], serial_data_2};
          if (exp_bits.size() == 0) begin
            fail("bit_unexpected", $sformatf("serial_clock rise %0d with nothing expected", edge_cnt));
          end else begin
            e = exp_bits.pop_front();
            check($sformatf("data_1_edge%0d", edge_cnt), 64'(serial_data_1), 64'(e.b1));
            check($sformatf("data_2_edge%0d", edge_cnt), 64'(serial_data_2), 64'(e.b2));
          end
        end
        if (busy && serial_load) begin
          load_width++;
          if (!prev_load) load_pulses++;
        end
        if (done) begin
          done_cnt++;
          check("done_single_cycle", 64'(prev_done), 64'(0));
          if (exp_xfer.size() == 0) begin
            fail("done_unexpected", $sformatf("done with no transfer outstanding, busy_cnt=%0d", busy_cnt));
          end else begin
            x = exp_xfer.pop_front();
            check("busy_cycles", 64'(busy_cnt), 64'(x.busy_len));
            check("clock_edges", 64'(edge_cnt), 64'(x.edges));
            check("load_pulses", 64'(load_pulses), 64'(1));
            check("load_width", 64'(load_width), 64'(CLKDIV));
            check("done_after_busy_fall", 64'({prev_busy, busy}), 64'(2'b10));
            check("bits_left", 64'(exp_bits.size()), 64'(0));
            check("idle_outputs", 64'({serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}),
                  64'(5'b00100));
            for (int k = 0; k < NPADS; k++) begin
              check($sformatf("chain1_pad%0d", k), 64'(chain1[k*CFG_BITS +: CFG_BITS]), 64'(reg1[k]));
              check($sformatf("chain2_pad%0d", k), 64'(chain2[k*CFG_BITS +: CFG_BITS]), 64'(reg2[k]));
            end
          end
          busy_cnt = 0; edge_cnt = 0; load_pulses = 0; load_width = 0;
        end
        prev_clk  = serial_clock;
        prev_load = serial_load;
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  // Queue the expected chain stream: pad NPADS-1 first, each word MSB first.
  task automatic start_xfer();
    bits_t e;
    xfer_t x;
    for (int p = NPADS - 1; p >= 0; p--) begin
      for (int b = CFG_BITS - 1; b >= 0; b--) begin
        e.b1 = reg1[p][b];
        e.b2 = reg2[p][b];
        exp_bits.push_back(e);
      end
    end
    x.busy_len = BUSY_LEN;
    x.edges    = NBITS;
    exp_xfer.push_back(x);
    xfer_start = 1'b1;
    @(negedge wb_clk_i);
    xfer_start = 1'b0;
  endtask

  task automatic wait_xfer(input string name);
    for (int i = 0; i < BUSY_LEN + 50; i++) begin
      @(negedge wb_clk_i);
      if (exp_xfer.size() == 0) break;
    end
    if (exp_xfer.size() != 0) begin
      fail(name, $sformatf("timeout, busy=%0b bits_left=%0d", busy, exp_bits.size()));
      exp_xfer.delete();
      exp_bits.delete();
    end
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_busy"},   64'(busy), 64'(0));
    check({name, "_done"},   64'(done), 64'(0));
    check({name, "_cfg_idx"}, 64'(cfg_idx), 64'(0));
    check({name, "_serial"}, 64'({serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}),
          64'(5'b00000));
  endtask

  initial begin
    logic [4:0] drv;
    int         done_before;

    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = '0;
      reg2[k] = '0;
    end

    // Reset values, then release.
    repeat (3) @(negedge wb_clk_i);
    check_reset_vals("reset");
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);
    check("resetn_after_release", 64'(serial_resetn), 64'(1));
    check("busy_after_release", 64'(busy), 64'(0));

    // Full transfer with constant words.
    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = 13'h1803;
      reg2[k] = 13'h0403;
    end
    start_xfer();
    wait_xfer("xfer_const");

    // Per-pad pattern: chain 1 gets the index, chain 2 its complement.
    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = CFG_BITS'(k);
      reg2[k] = ~CFG_BITS'(k);
    end
    start_xfer();
    wait_xfer("xfer_index");

    // Random words with a re-pulsed start 500 cycles in, which must be ignored.
    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = CFG_BITS'($urandom);
      reg2[k] = CFG_BITS'($urandom);
    end
    repeat ($urandom_range(1, 7)) @(negedge wb_clk_i);
    start_xfer();
    repeat (499) @(negedge wb_clk_i);
    xfer_start = 1'b1;
    @(negedge wb_clk_i);
    xfer_start = 1'b0;
    wait_xfer("xfer_repulse");

    // Bit-bang passthrough with one cycle of latency.
    bitbang_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drv = 5'($urandom);
      {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = drv;
      @(negedge wb_clk_i);
      check($sformatf("bb_out_%0d", i),
            64'({serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}), 64'(drv));
      check($sformatf("bb_busy_%0d", i), 64'(busy), 64'(0));
    end

    // Start request together with bit-bang enable: no transfer starts.
    drv = 5'($urandom);
    {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = drv;
    xfer_start = 1'b1;
    @(negedge wb_clk_i);
    xfer_start = 1'b0;
    check("collide_out", 64'({serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}),
          64'(drv));
    repeat (6) @(negedge wb_clk_i);
    check("collide_busy", 64'(busy), 64'(0));
    bitbang_en = 1'b0;
    {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 5'b00000;
    @(negedge wb_clk_i);
    check("hw_idle_out", 64'({serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2}),
          64'(5'b00100));

    // Reset during bit 5 of pad 10 (the 110th chain clock of the transfer).
    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = CFG_BITS'($urandom);
      reg2[k] = CFG_BITS'($urandom);
    end
    start_xfer();
    for (int i = 0; i < BUSY_LEN; i++) begin
      if (edge_cnt >= (NPADS - 1 - 10) * CFG_BITS + 6) break;
      @(negedge wb_clk_i);
    end
    check("reached_pad10_bit5", 64'(edge_cnt >= (NPADS - 1 - 10) * CFG_BITS + 6), 64'(1));
    done_before = done_cnt;
    #2;
    wb_rstn_i = 1'b0;
    exp_bits.delete();
    exp_xfer.delete();
    #1;
    check_reset_vals("midreset");
    repeat (3) @(negedge wb_clk_i);
    #2;
    wb_rstn_i = 1'b1;
    repeat (BUSY_LEN / 2) @(negedge wb_clk_i);
    check("no_done_after_abort", 64'(done_cnt), 64'(done_before));
    check("idle_after_abort", 64'(busy), 64'(0));

    // A following transfer completes normally.
    for (int k = 0; k < NPADS; k++) begin
      reg1[k] = CFG_BITS'($urandom);
      reg2[k] = CFG_BITS'($urandom);
    end
    start_xfer();
    wait_xfer("xfer_after_reset");
    check("done_count_total", 64'(done_cnt), 64'(done_before + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
